// File: rtl/multi_bank_rd_mux.sv
// Latency-aligned read-return mux for the multi-bank memory.
// Tracks {valid, sel} per read and steers the addressed bank onto one port.
module multi_bank_rd_mux #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_BANKS  = 4,
  parameter int SEL_W      = 2,
  parameter int RD_LATENCY = 2,
  parameter int OUT_REG    = 1
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_rd_en,
  input  logic [SEL_W-1:0]                i_bank_sel,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] i_bank_rdata,
  input  logic                            i_flush,
  output logic [DATA_WIDTH-1:0]           o_rdata,
  output logic                            o_rvalid,
  output logic [SEL_W-1:0]                o_rbank,
  output logic                            o_err,
  output logic [3:0]                      o_pending
);

  localparam logic [SEL_W:0] NB = (SEL_W+1)'(NUM_BANKS);

  logic [RD_LATENCY-1:0] vld_q;
  logic [SEL_W-1:0]      sel_q [RD_LATENCY];

  logic                  fin_vld;
  logic [SEL_W-1:0]      fin_sel;
  logic                  fin_err;
  logic [DATA_WIDTH-1:0] word;
  logic                  ret;
  logic [3:0]            pend_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_q <= '0;
      for (int n = 0; n < RD_LATENCY; n++) begin
        sel_q[n] <= '0;
      end
    end else if (i_flush) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= i_rd_en;
      sel_q[0] <= i_bank_sel;
      for (int n = 1; n < RD_LATENCY; n++) begin
        vld_q[n] <= vld_q[n-1];
        sel_q[n] <= sel_q[n-1];
      end
    end
  end

  assign fin_vld = vld_q[RD_LATENCY-1];
  assign fin_sel = sel_q[RD_LATENCY-1];
  assign fin_err = {1'b0, fin_sel} >= NB;

  // Unmatched selects leave the word at zero.
  always_comb begin
    word = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if ({1'b0, fin_sel} == (SEL_W+1)'(b)) begin
        word = i_bank_rdata[b*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_reg
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          o_rvalid <= 1'b0;
          o_err    <= 1'b0;
          o_rdata  <= '0;
          o_rbank  <= '0;
        end else if (i_flush) begin
          o_rvalid <= 1'b0;
          o_err    <= 1'b0;
        end else begin
          o_rvalid <= fin_vld;
          o_err    <= fin_vld & fin_err;
          if (fin_vld) begin
            o_rdata <= word;
            o_rbank <= fin_sel;
          end
        end
      end
      assign ret = o_rvalid;
    end else begin : g_comb
      always_comb begin
        o_rvalid = fin_vld;
        o_err    = fin_vld & fin_err;
        o_rdata  = fin_vld ? word : '0;
        o_rbank  = fin_vld ? fin_sel : '0;
      end
      assign ret = fin_vld;
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pend_q <= '0;
    end else if (i_flush) begin
      pend_q <= '0;
    end else if (i_rd_en && !ret) begin
      pend_q <= pend_q + 4'd1;
    end else if (!i_rd_en && ret) begin
      pend_q <= pend_q - 4'd1;
    end
  end

  assign o_pending = pend_q;

endmodule

// File: tb/tb_multi_bank_rd_mux.sv
// Bench for multi_bank_rd_mux: six parameter sets on shared stimulus,
// directed table on the default set plus a transaction-level model.
module tb_multi_bank_rd_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        rd_en;
  logic        flush;
  logic [2:0]  sel;
  logic [39:0] bdata;

  logic [7:0] q   [6];
  logic       rv  [6];
  logic       er  [6];
  logic [3:0] pd  [6];
  logic [1:0] rbn [5];
  logic [2:0] rb5;

  multi_bank_rd_mux #(.DATA_WIDTH(8), .NUM_BANKS(4), .SEL_W(2),
    .RD_LATENCY(2), .OUT_REG(1)) u0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_rd_en(rd_en),
    .i_bank_sel(sel[1:0]), .i_bank_rdata(bdata[31:0]),
    .i_flush(flush), .o_rdata(q[0]), .o_rvalid(rv[0]),
    .o_rbank(rbn[0]), .o_err(er[0]), .o_pending(pd[0]));

  multi_bank_rd_mux #(.DATA_WIDTH(8), .NUM_BANKS(3), .SEL_W(2),
    .RD_LATENCY(2), .OUT_REG(1)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_rd_en(rd_en),
    .i_bank_sel(sel[1:0]), .i_bank_rdata(bdata[23:0]),
    .i_flush(flush), .o_rdata(q[1]), .o_rvalid(rv[1]),
    .o_rbank(rbn[1]), .o_err(er[1]), .o_pending(pd[1]));

  multi_bank_rd_mux #(.DATA_WIDTH(8), .NUM_BANKS(4), .SEL_W(2),
    .RD_LATENCY(1), .OUT_REG(0)) u2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_rd_en(rd_en),
    .i_bank_sel(sel[1:0]), .i_bank_rdata(bdata[31:0]),
    .i_flush(flush), .o_rdata(q[2]), .o_rvalid(rv[2]),
    .o_rbank(rbn[2]), .o_err(er[2]), .o_pending(pd[2]));

  multi_bank_rd_mux #(.DATA_WIDTH(8), .NUM_BANKS(4), .SEL_W(2),
    .RD_LATENCY(4), .OUT_REG(0)) u3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_rd_en(rd_en),
    .i_bank_sel(sel[1:0]), .i_bank_rdata(bdata[31:0]),
    .i_flush(flush), .o_rdata(q[3]), .o_rvalid(rv[3]),
    .o_rbank(rbn[3]), .o_err(er[3]), .o_pending(pd[3]));

  multi_bank_rd_mux #(.DATA_WIDTH(8), .NUM_BANKS(4), .SEL_W(2),
    .RD_LATENCY(1), .OUT_REG(1)) u4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_rd_en(rd_en),
    .i_bank_sel(sel[1:0]), .i_bank_rdata(bdata[31:0]),
    .i_flush(flush), .o_rdata(q[4]), .o_rvalid(rv[4]),
    .o_rbank(rbn[4]), .o_err(er[4]), .o_pending(pd[4]));

  multi_bank_rd_mux #(.DATA_WIDTH(8), .NUM_BANKS(5), .SEL_W(3),
    .RD_LATENCY(4), .OUT_REG(1)) u5 (
    .i_clk(clk), .i_rst_n(rst_n), .i_rd_en(rd_en),
    .i_bank_sel(sel), .i_bank_rdata(bdata),
    .i_flush(flush), .o_rdata(q[5]), .o_rvalid(rv[5]),
    .o_rbank(rb5), .o_err(er[5]), .o_pending(pd[5]));

  int nb_t [6] = '{4, 3, 4, 4, 4, 5};
  int sw_t [6] = '{2, 2, 2, 2, 2, 3};
  int lt_t [6] = '{2, 2, 1, 4, 1, 4};
  int rg_t [6] = '{1, 1, 0, 0, 1, 1};

  // Acceptance history by edge; a flush or reset at edge e kills all k <= e.
  bit         acc [4096];
  logic [2:0] sh  [4096];
  int         ecount;
  int         kill_e;

  logic       m_rv [6];
  logic       m_er [6];
  logic [7:0] m_q  [6];
  int         m_b  [6];

  int nvec;
  int nmis;

  typedef struct {
    logic        rd;
    logic [2:0]  s;
    logic [31:0] d;
    logic        f;
    logic        v;
    logic [7:0]  q;
    logic [1:0]  b;
    logic        e;
    logic [3:0]  p;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(logic r, logic [2:0] s, logic [31:0] d,
                              logic f, logic v, logic [7:0] qq,
                              logic [1:0] b, logic e, logic [3:0] p);
    vec_t x;
    x.rd = r; x.s = s; x.d = d; x.f = f;
    x.v = v; x.q = qq; x.b = b; x.e = e; x.p = p;
    return x;
  endfunction

  function automatic bit alive(int k);
    if (k < 0 || k <= kill_e) return 1'b0;
    return acc[k];
  endfunction

  function automatic logic [7:0] slice(int s);
    return bdata[s*8 +: 8];
  endfunction

  function automatic int getrb(int i);
    if (i == 5) return int'(rb5);
    return int'(rbn[i]);
  endfunction

  function automatic logic [39:0] rnd40();
    logic [63:0] v;
    v = {$urandom(), $urandom()};
    return v[39:0];
  endfunction

  task automatic chk(string nm, int act, int exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [2:0] s,
                      input logic [39:0] d, input logic f,
                      input logic rs);
    int t;
    @(negedge clk);
    rd_en = r; sel = s; bdata = d; flush = f; rst_n = rs;
    #1;
    t = ecount + 1;
    if (!rs) begin
      kill_e = t;
      for (int i = 0; i < 6; i++) begin
        m_rv[i] = 0; m_er[i] = 0; m_q[i] = 0; m_b[i] = 0;
      end
    end
    for (int i = 0; i < 6; i++) begin
      int L, R, k, ms, np, eb;
      bit a, erv, eer;
      logic [7:0] eq;
      L = lt_t[i]; R = rg_t[i];
      if (R == 0) begin
        k = t - L;
        a = alive(k);
        ms = a ? (int'(sh[k]) & ((1 << sw_t[i]) - 1)) : 0;
        erv = a;
        eer = a && (ms >= nb_t[i]);
        eq = (a && !eer) ? slice(ms) : 8'h00;
        eb = ms;
      end else begin
        erv = m_rv[i]; eer = m_er[i]; eq = m_q[i]; eb = m_b[i];
      end
      np = 0;
      for (int kk = t - L - R; kk < t; kk++) begin
        if (alive(kk)) np++;
      end
      chk($sformatf("u%0d.rvalid e%0d", i, t), int'(rv[i]), int'(erv));
      chk($sformatf("u%0d.err e%0d", i, t), int'(er[i]), int'(eer));
      chk($sformatf("u%0d.rdata e%0d", i, t), int'(q[i]), int'(eq));
      chk($sformatf("u%0d.rbank e%0d", i, t), getrb(i), eb);
      chk($sformatf("u%0d.pending e%0d", i, t), int'(pd[i]), np);
    end
    if (!rs) begin
      acc[t] = 0;
    end else if (f) begin
      acc[t] = 0;
      for (int i = 0; i < 6; i++) begin
        m_rv[i] = 0; m_er[i] = 0;
      end
      kill_e = t;
    end else begin
      acc[t] = r;
      sh[t] = s;
      for (int i = 0; i < 6; i++) begin
        if (rg_t[i] != 0) begin
          int k, ms;
          k = t - lt_t[i];
          if (alive(k)) begin
            ms = int'(sh[k]) & ((1 << sw_t[i]) - 1);
            m_rv[i] = 1;
            m_er[i] = ms >= nb_t[i];
            m_q[i] = m_er[i] ? 8'h00 : slice(ms);
            m_b[i] = ms;
          end else begin
            m_rv[i] = 0; m_er[i] = 0;
          end
        end
      end
    end
    ecount = t;
  endtask

  initial begin
    nvec = 0; nmis = 0;
    ecount = 0; kill_e = 0;
    rst_n = 0; rd_en = 0; flush = 0; sel = 0; bdata = 0;
    for (int i = 0; i < 6; i++) begin
      m_rv[i] = 0; m_er[i] = 0; m_q[i] = 0; m_b[i] = 0;
    end

    tbl.push_back(mk(1, 2, 32'h0,        0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 0, 32'h0,        0, 0, 8'h00, 0, 0, 1));
    tbl.push_back(mk(0, 0, 32'h00A50000, 0, 0, 8'h00, 0, 0, 1));
    tbl.push_back(mk(0, 0, 32'h0,        0, 1, 8'hA5, 2, 0, 1));
    tbl.push_back(mk(0, 0, 32'h0,        0, 0, 8'hA5, 2, 0, 0));
    tbl.push_back(mk(1, 0, 32'h0,        0, 0, 8'hA5, 2, 0, 0));
    tbl.push_back(mk(1, 1, 32'h0,        0, 0, 8'hA5, 2, 0, 1));
    tbl.push_back(mk(1, 2, 32'h00000010, 0, 0, 8'hA5, 2, 0, 2));
    tbl.push_back(mk(1, 3, 32'h00002100, 0, 1, 8'h10, 0, 0, 3));
    tbl.push_back(mk(0, 0, 32'h00320000, 0, 1, 8'h21, 1, 0, 3));
    tbl.push_back(mk(0, 0, 32'h43000000, 0, 1, 8'h32, 2, 0, 2));
    tbl.push_back(mk(0, 0, 32'hFFFFFFFF, 0, 1, 8'h43, 3, 0, 1));
    tbl.push_back(mk(0, 0, 32'h0,        0, 0, 8'h43, 3, 0, 0));
    tbl.push_back(mk(1, 1, 32'h12345678, 0, 0, 8'h43, 3, 0, 0));
    tbl.push_back(mk(0, 0, 32'hAAAAAAAA, 0, 0, 8'h43, 3, 0, 1));
    tbl.push_back(mk(0, 0, 32'h00005C00, 0, 0, 8'h43, 3, 0, 1));
    tbl.push_back(mk(0, 0, 32'h55555555, 0, 1, 8'h5C, 1, 0, 1));
    tbl.push_back(mk(0, 0, 32'hAAAAAAAA, 0, 0, 8'h5C, 1, 0, 0));
    tbl.push_back(mk(0, 0, 32'h55555555, 0, 0, 8'h5C, 1, 0, 0));
    tbl.push_back(mk(0, 0, 32'hAAAAAAAA, 0, 0, 8'h5C, 1, 0, 0));
    tbl.push_back(mk(0, 0, 32'h55555555, 0, 0, 8'h5C, 1, 0, 0));
    tbl.push_back(mk(0, 0, 32'hAAAAAAAA, 0, 0, 8'h5C, 1, 0, 0));
    tbl.push_back(mk(1, 0, 32'h0,        0, 0, 8'h5C, 1, 0, 0));
    tbl.push_back(mk(1, 3, 32'h0,        0, 0, 8'h5C, 1, 0, 1));
    tbl.push_back(mk(1, 2, 32'hFFFFFFFF, 1, 0, 8'h5C, 1, 0, 2));
    tbl.push_back(mk(0, 0, 32'hFFFFFFFF, 0, 0, 8'h5C, 1, 0, 0));
    tbl.push_back(mk(0, 0, 32'hFFFFFFFF, 0, 0, 8'h5C, 1, 0, 0));
    tbl.push_back(mk(0, 0, 32'hFFFFFFFF, 0, 0, 8'h5C, 1, 0, 0));
    tbl.push_back(mk(1, 3, 32'h0,        0, 0, 8'h5C, 1, 0, 0));
    tbl.push_back(mk(0, 0, 32'h0,        0, 0, 8'h5C, 1, 0, 1));
    tbl.push_back(mk(0, 0, 32'h9E000000, 0, 0, 8'h5C, 1, 0, 1));
    tbl.push_back(mk(0, 0, 32'h0,        0, 1, 8'h9E, 3, 0, 1));
    tbl.push_back(mk(0, 0, 32'h0,        0, 0, 8'h9E, 3, 0, 0));

    repeat (3) begin
      step(1, 2, rnd40(), 0, 0);
      chk("rst.rvalid", int'(rv[0]), 0);
      chk("rst.rdata", int'(q[0]), 0);
      chk("rst.pending", int'(pd[0]), 0);
    end

    foreach (tbl[n]) begin
      step(tbl[n].rd, tbl[n].s, {8'h00, tbl[n].d}, tbl[n].f, 1);
      chk($sformatf("tbl%0d.rvalid", n), int'(rv[0]), int'(tbl[n].v));
      chk($sformatf("tbl%0d.rdata", n), int'(q[0]), int'(tbl[n].q));
      chk($sformatf("tbl%0d.rbank", n), int'(rbn[0]), int'(tbl[n].b));
      chk($sformatf("tbl%0d.err", n), int'(er[0]), int'(tbl[n].e));
      chk($sformatf("tbl%0d.pending", n), int'(pd[0]), int'(tbl[n].p));
    end

    repeat (4) step(0, 0, 40'h0, 0, 1);
    step(1, 3, 40'h0, 0, 1);
    step(0, 0, 40'h0, 0, 1);
    step(0, 0, 40'hFF_FFFF_FFFF, 0, 1);
    step(0, 0, 40'h0, 0, 1);
    chk("nb3.bad.rvalid", int'(rv[1]), 1);
    chk("nb3.bad.err", int'(er[1]), 1);
    chk("nb3.bad.rdata", int'(q[1]), 0);
    chk("nb3.bad.rbank", int'(rbn[1]), 3);
    step(1, 1, 40'h0, 0, 1);
    chk("nb3.strobe.err", int'(er[1]), 0);
    step(0, 0, 40'h0, 0, 1);
    step(0, 0, 40'h00_0000_7700, 0, 1);
    step(0, 0, 40'h0, 0, 1);
    chk("nb3.ok.rvalid", int'(rv[1]), 1);
    chk("nb3.ok.err", int'(er[1]), 0);
    chk("nb3.ok.rdata", int'(q[1]), 8'h77);

    step(1, 1, rnd40(), 0, 1);
    step(1, 2, rnd40(), 0, 1);
    step(1, 3, rnd40(), 0, 0);
    chk("midrst.rvalid", int'(rv[0]), 0);
    chk("midrst.pending", int'(pd[0]), 0);
    repeat (4) begin
      step(0, 0, rnd40(), 0, 1);
      chk("postrst.rvalid", int'(rv[0]), 0);
    end
    step(1, 0, 40'h0, 0, 1);
    step(0, 0, 40'h0, 0, 1);
    step(0, 0, 40'h00_0000_003C, 0, 1);
    chk("postrst.early", int'(rv[0]), 0);
    step(0, 0, 40'h0, 0, 1);
    chk("postrst.rvalid1", int'(rv[0]), 1);
    chk("postrst.rdata", int'(q[0]), 8'h3C);
    chk("postrst.rbank", int'(rbn[0]), 0);

    for (int n = 0; n < 1500; n++) begin
      logic r, f, rs;
      logic [2:0] s;
      r  = $urandom_range(3) != 0;
      s  = 3'($urandom_range(7));
      f  = $urandom_range(39) == 0;
      rs = $urandom_range(199) != 0;
      step(r, s, rnd40(), f, rs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
